result_requantizer: RTL and testbench

- Drain-side counterpart of the MAC datapath. The MAC chain widens 8-bit activations into RESULT_WIDTH accumulators; this block narrows them back.
- Takes accumulated results from the end of a MAC column and requantizes each one to a DATA_WIDTH activation: scale multiply, rounding right-shift, zero-point add, unsigned saturation.
- 2-stage pipeline with valid/ready on both sides. Its output feeds the next layer's input buffer.

---
 rtl/result_requantizer.sv | 128 ++++++++++++
 tb/tb_result_requantizer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_requantizer.sv
// Requantizes RESULT_WIDTH accumulator results to DATA_WIDTH activations in a 2-stage pipeline
// (scale multiply, rounding right-shift, zero-point add, unsigned clamp). Optional macro: REQUANT_SAT_COUNT_EN.
module result_requantizer #(
    parameter int DATA_WIDTH   = 8,
    parameter int RESULT_WIDTH = 16,
    parameter int SHIFT_WIDTH  = 5
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    config_load,
    input  logic [7:0]              config_scale,
    input  logic [SHIFT_WIDTH-1:0]  config_shift,
    input  logic [DATA_WIDTH-1:0]   config_zero_point,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RESULT_WIDTH-1:0] in_value,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_value,
    output logic                    out_last,
    output logic                    busy
`ifdef REQUANT_SAT_COUNT_EN
    ,
    output logic [15:0]             sat_count
`endif
);
    localparam int PW = RESULT_WIDTH + 8;
    localparam int RW = PW + 1;
    localparam logic [RW-1:0] OUT_MAX = {{(RW-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    logic [7:0]             scale_q;
    logic [SHIFT_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0]  zp_q;

    logic                   s1_valid_q, s1_last_q;
    logic [PW-1:0]          s1_product_q, s1_product_d;
    logic                   s2_valid_q, s2_last_q;
    logic [DATA_WIDTH-1:0]  s2_value_q, s2_value_d;

    logic                   en, cfg_accept;
    logic [RW-1:0]          round_add, rounded, sum;
    logic                   sat;

    // Both stages move together; a stalled output freezes the whole pipe.
    assign en         = !s2_valid_q || out_ready;
    assign in_ready   = en;
    assign busy       = s1_valid_q || s2_valid_q;
    assign cfg_accept = config_load && !busy && !in_valid;

    assign out_valid  = s2_valid_q;
    assign out_value  = s2_value_q;
    assign out_last   = s2_last_q;

    assign s1_product_d = PW'(in_value) * PW'(scale_q);

    // Rounding addend lives in RW bits, so very large shifts simply lose it.
    always_comb begin
        round_add = '0;
        if (shift_q != '0) begin
            round_add = RW'(1) << (shift_q - SHIFT_WIDTH'(1));
        end
        rounded    = ({1'b0, s1_product_q} + round_add) >> shift_q;
        sum        = rounded + RW'(zp_q);
        sat        = sum > OUT_MAX;
        s2_value_d = sat ? {DATA_WIDTH{1'b1}} : sum[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scale_q <= 8'd1;
            shift_q <= '0;
            zp_q    <= '0;
        end else if (cfg_accept) begin
            scale_q <= config_scale;
            shift_q <= config_shift;
            zp_q    <= config_zero_point;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_product_q <= '0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_value_q   <= '0;
        end else if (en) begin
            s1_valid_q   <= in_valid;
            s1_last_q    <= in_last;
            s1_product_q <= s1_product_d;
            s2_valid_q   <= s1_valid_q;
            s2_last_q    <= s1_last_q;
            s2_value_q   <= s2_value_d;
        end
    end

`ifdef REQUANT_SAT_COUNT_EN
    logic        s2_sat_q;
    logic [15:0] sat_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_sat_q <= 1'b0;
        end else if (en) begin
            s2_sat_q <= sat;
        end
    end

    // Counts clamped results as they leave; sticks at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_count_q <= '0;
        end else if (cfg_accept) begin
            sat_count_q <= '0;
        end else if (s2_valid_q && out_ready && s2_sat_q && (sat_count_q != 16'hFFFF)) begin
            sat_count_q <= sat_count_q + 16'd1;
        end
    end

    assign sat_count = sat_count_q;
`else
    logic unused_sat;
    assign unused_sat = sat;
`endif

endmodule

// File: tb/tb_result_requantizer.sv
// Self-checking bench for result_requantizer; honours REQUANT_SAT_COUNT_EN when defined.
module tb_result_requantizer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        config_load;
    logic [7:0]  config_scale;
    logic [4:0]  config_shift;
    logic [7:0]  config_zero_point;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_value;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_value;
    logic        out_last;
    logic        busy;
`ifdef REQUANT_SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    result_requantizer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .config_load       (config_load),
        .config_scale      (config_scale),
        .config_shift      (config_shift),
        .config_zero_point (config_zero_point),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_value          (in_value),
        .in_last           (in_last),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_value         (out_value),
        .out_last          (out_last),
        .busy              (busy)
`ifdef REQUANT_SAT_COUNT_EN
        ,
        .sat_count         (sat_count)
`endif
    );

    always #5 clk = ~clk;

    // entry = {sat, last, value}
    logic [9:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cfg_scale = 1, cfg_shift = 0, cfg_zp = 0;
    int exp_sat = 0;
    bit flow_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] model(input int unsigned v, input logic last);
        longint unsigned p, add, r, s;
        logic [7:0] val;
        p   = longint'(v) * longint'(cfg_scale);
        add = 0;
        if (cfg_shift > 0) add = (64'd1 << (cfg_shift - 1)) & ((64'd1 << 25) - 1);
        r   = (p + add) >> cfg_shift;
        s   = r + longint'(cfg_zp);
        val = (s > 255) ? 8'hFF : s[7:0];
        return {(s > 255), last, val};
    endfunction

    // Scoreboard drain side: every output transfer pops one expected entry.
    always @(negedge clk) begin
        logic [9:0] e;
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got value=%0d last=%0d, expected none", out_value, out_last);
            end else begin
                e = exp_q.pop_front();
                if ({out_last, out_value} !== e[8:0]) begin
                    errors++;
                    $display("FAIL output got value=%0d last=%0d, expected value=%0d last=%0d",
                             out_value, out_last, e[7:0], e[8]);
                end
                if (e[9] && exp_sat < 65535) exp_sat++;
            end
        end
    end

    // Present one element and hold it until accepted; expv<0 means use the model value.
    task automatic send(input int v, input bit last, input int expv);
        logic [9:0] e;
        bit ok;
        in_value = 16'(v);
        in_last  = last;
        in_valid = 1'b1;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout value=%0d got no in_ready, expected in_ready=1", v);
        end else begin
            e = model(v, last);
            if (expv >= 0) e[7:0] = 8'(expv);
            exp_q.push_back(e);
        end
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        idle();
        for (int k = 0; k < 300; k++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            tick();
        end
        checks++;
        if (!ok || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got busy=%0d pending=%0d, expected busy=0 pending=0", busy, exp_q.size());
            exp_q.delete();
        end
`ifdef REQUANT_SAT_COUNT_EN
        checks++;
        if (sat_count !== 16'(exp_sat)) begin
            errors++;
            $display("FAIL sat_count got %0d, expected %0d", sat_count, exp_sat);
        end
`endif
    endtask

    task automatic load_cfg(input int sc, input int sh, input int zp, input bit honoured);
        config_scale      = 8'(sc);
        config_shift      = 5'(sh);
        config_zero_point = 8'(zp);
        config_load       = 1'b1;
        tick();
        config_load = 1'b0;
        if (honoured) begin
            cfg_scale = sc;
            cfg_shift = sh;
            cfg_zp    = zp;
            exp_sat   = 0;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_value !== 8'd0 || out_last !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got valid=%0d value=%0d last=%0d busy=%0d, expected all 0",
                     out_valid, out_value, out_last, busy);
        end
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0d, expected 1", in_ready);
        end
`ifdef REQUANT_SAT_COUNT_EN
        checks++;
        if (sat_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_sat_count got %0d, expected 0", sat_count);
        end
`endif
    endtask

    task automatic test_basic();
        load_cfg(3, 4, 0, 1);
        send(1000, 0, 188);
        idle();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL latency_1 got out_valid=%0d busy=%0d, expected 0 and 1", out_valid, busy);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_value !== 8'd188) begin
            errors++;
            $display("FAIL latency_2 got out_valid=%0d value=%0d, expected 1 and 188", out_valid, out_value);
        end
        drain();
    endtask

    task automatic test_rounding();
        load_cfg(1, 4, 0, 1);
        send(24, 0, 2);
        send(23, 0, 1);
        send(8, 0, 1);
        send(7, 0, 0);
        drain();
        load_cfg(1, 0, 0, 1);
        send(200, 0, 200);
        drain();
        load_cfg(0, 3, 77, 1);
        send(65535, 0, 77);
        send(1234, 1, 77);
        drain();
    endtask

    task automatic test_saturation();
        load_cfg(255, 0, 0, 1);
        send(65535, 0, 255);
        drain();
        load_cfg(3, 4, 100, 1);
        send(1000, 0, 255);
        send(1000, 0, 255);
        drain();
`ifdef REQUANT_SAT_COUNT_EN
        checks++;
        if (sat_count !== 16'd2) begin
            errors++;
            $display("FAIL sat_count_two got %0d, expected 2", sat_count);
        end
`endif
    endtask

    task automatic test_back_pressure();
        logic [7:0] held_v;
        logic held_l;
        bit stalled;
        bit pat[4] = '{1, 0, 0, 1};
        load_cfg(1, 0, 0, 1);
        flow_done = 0;
        stalled = 0;
        fork
            begin
                for (int i = 1; i <= 10; i++) send(i, (i == 10), i);
                drain();
                flow_done = 1;
            end
            begin
                for (int k = 0; !flow_done; k++) begin
                    out_ready = pat[k % 4];
                    tick();
                end
                out_ready = 1'b1;
            end
            begin
                while (!flow_done) begin
                    @(negedge clk);
                    checks++;
                    if (in_ready !== (!out_valid || out_ready)) begin
                        errors++;
                        $display("FAIL in_ready_rule got %0d, expected %0d", in_ready, (!out_valid || out_ready));
                    end
                    if (stalled) begin
                        checks++;
                        if (out_value !== held_v || out_last !== held_l || out_valid !== 1'b1) begin
                            errors++;
                            $display("FAIL stall_hold got value=%0d last=%0d, expected value=%0d last=%0d",
                                     out_value, out_last, held_v, held_l);
                        end
                    end
                    stalled = out_valid && !out_ready;
                    held_v  = out_value;
                    held_l  = out_last;
                end
            end
        join
    endtask

    task automatic test_config_guard();
        load_cfg(1, 0, 0, 1);
        send(10, 0, 10);
        idle();
        load_cfg(2, 0, 0, 0);
        send(20, 0, 20);
        drain();
        load_cfg(2, 0, 0, 1);
        send(50, 0, 100);
        drain();
    endtask

    task automatic test_random();
        for (int b = 0; b < 4; b++) begin
            load_cfg($urandom_range(0, 255), $urandom_range(0, 31), $urandom_range(0, 255), 1);
            flow_done = 0;
            fork
                begin
                    for (int i = 0; i < 25; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            idle();
                            tick();
                        end
                        send($urandom_range(0, 65535), $urandom_range(0, 1), -1);
                    end
                    drain();
                    flow_done = 1;
                end
                begin
                    while (!flow_done) begin
                        out_ready = ($urandom_range(0, 2) != 0);
                        tick();
                    end
                    out_ready = 1'b1;
                end
            join
        end
    endtask

    task automatic test_reset_mid_stream();
        load_cfg(5, 0, 0, 1);
        out_ready = 1'b1;
        send(1, 0, 5);
        send(2, 0, 10);
        idle();
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got out_valid=%0d busy=%0d, expected 1 and 1", out_valid, busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got out_valid=%0d busy=%0d, expected 0 and 0", out_valid, busy);
        end
        exp_q.delete();
        cfg_scale = 1;
        cfg_shift = 0;
        cfg_zp    = 0;
        exp_sat   = 0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_output got out_valid=%0d, expected 0", out_valid);
        end
        send(200, 1, 200);
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n           = 1'b0;
        config_load       = 1'b0;
        config_scale      = 8'd0;
        config_shift      = 5'd0;
        config_zero_point = 8'd0;
        in_valid          = 1'b0;
        in_value          = 16'd0;
        in_last           = 1'b0;
        out_ready         = 1'b1;
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_back_pressure();
        test_config_guard();
        test_random();
        test_reset_mid_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
